barrett_sched: RTL and testbench

Round-robin scheduler and configuration controller that shares one external `barrett_pipelined` reduction unit among `NUM_REQ` requesters. It holds the active modulus and μ in configuration registers. Each accepted operand is tagged with its requester ID through a tag pipeline matched to the reduction latency, and each result is returned to the requester that issued it. Modulus changes are made safe by draining the pipeline before the registers are written. The block sits between the requester ports and the top-level instance of `barrett_pipelined`.

---
 rtl/barrett_sched_pkg.sv | 34 +++
 rtl/barrett_sched_if.sv | 23 ++
 rtl/barrett_sched_rr_arbiter.sv | 48 ++++
 rtl/barrett_sched.sv | 183 ++++++++++++++++++
 tb/tb_barrett_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/barrett_sched_pkg.sv
// Shared types and widths for the Barrett reduction scheduler.
package barrett_pkg;

    localparam int DATA_W      = 64;
    localparam int RES_W       = 128;

    // Default requester count; the tag ID field is sized from it.
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Next in-flight count; the caller flags overflow separately.
    function automatic int unsigned inflight_next(input int unsigned cnt,
                                                  input logic inc,
                                                  input logic dec);
        int unsigned n;
        n = cnt;
        if (inc && !dec) n = cnt + 1;
        if (dec && !inc) n = (cnt == 0) ? 0 : cnt - 1;
        return n;
    endfunction

endpackage

// File: rtl/barrett_sched_if.sv
// Bus between the scheduler and the shared barrett_pipelined unit.
// master: scheduler side, slave: reduction unit side.
interface barrett_sched_if;
    import barrett_pkg::*;

    logic              bm_start;
    logic [DATA_W-1:0] bm_x;
    logic [DATA_W-1:0] bm_m;
    logic [DATA_W-1:0] bm_mu;
    logic [RES_W-1:0]  bm_result;
    logic              bm_valid;

    modport master (
        output bm_start, bm_x, bm_m, bm_mu,
        input  bm_result, bm_valid
    );

    modport slave (
        input  bm_start, bm_x, bm_m, bm_mu,
        output bm_result, bm_valid
    );

endinterface

// File: rtl/barrett_sched_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching from last_grant+1,
// pointer moves only when the grant is actually accepted.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       accept_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Select the first valid requester after the last one served.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        cand     = '0;
        found    = 1'b0;
        if (en_i) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
                if (!found && req_i[cand]) begin
                    found       = 1'b1;
                    gnt_o[cand] = 1'b1;
                    gnt_id_o    = cand;
                end
            end
        end
    end

    // Priority pointer; reset value makes requester 0 first in line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else if (accept_i) begin
            last_q <= gnt_id_o;
        end
    end

endmodule

// File: rtl/barrett_sched.sv
// Shares one pipelined Barrett reduction unit among NUM_REQ requesters.
// Each issue carries a {valid, id} tag down a pipeline matched to the unit
// latency so the result can be routed back to the requester that sent it.
// A modulus change drains the pipeline first, so in-flight work always
// finishes with the m/mu it was issued with.
//
// state    | meaning
// ST_IDLE  | no modulus loaded, all requesters held off
// ST_RUN   | arbitrating, up to one issue per cycle
// ST_DRAIN | new modulus pending, waiting for in-flight work to retire
// ST_LOAD  | m/mu written this cycle, cfg_ready_o high
module barrett_sched
    import barrett_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int LATENCY = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_x_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic                           cfg_valid_i,
    input  logic [DATA_W-1:0]              cfg_m_i,
    input  logic [DATA_W-1:0]              cfg_mu_i,
    output logic                           cfg_ready_o,
    barrett_sched_if.master                bm,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    output logic [DATA_W-1:0]              resp_r_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY + 1);

    sched_state_e        state_q;
    logic [DATA_W-1:0]   m_q;
    logic [DATA_W-1:0]   mu_q;
    logic                cfg_ready_q;

    logic                arb_en;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    gnt_id;
    logic                hs;

    logic                iss_valid_q;
    logic [DATA_W-1:0]   iss_x_q;
    logic [IDX_W-1:0]    iss_id_q;

    tag_t                tag_q [LATENCY];
    tag_t                tag_out;
    logic                rsp_hit;

    logic [NUM_REQ-1:0]  resp_valid_d;
    logic [NUM_REQ-1:0]  resp_valid_q;
    logic [DATA_W-1:0]   resp_r_q;

    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                cnt_ovf;
    logic                err_d;
    logic                err_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (arb_en),
        .req_i    (req_valid_i),
        .accept_i (hs),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    // Grants only go to valid requesters, so any grant is a handshake.
    // A pending configuration blocks grants in the same cycle.
    always_comb begin
        arb_en  = (state_q == ST_RUN) && !cfg_valid_i;
        hs      = |gnt;
        tag_out = tag_q[LATENCY-1];
        rsp_hit = tag_out.valid && bm.bm_valid;

        resp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_d[i] = rsp_hit && (tag_out.id == ID_W'(i));
        end

        cnt_ovf = hs && !rsp_hit && (cnt_q == CNT_MAX);
        cnt_d   = cnt_ovf ? cnt_q
                          : CNT_W'(inflight_next(int'(cnt_q), hs, rsp_hit));

        err_d = err_q
              | (tag_out.valid != bm.bm_valid)
              | (bm.bm_valid && (|bm.bm_result[RES_W-1:DATA_W]))
              | cnt_ovf;
    end

    // Sequencing FSM with configuration registers and registered cfg_ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            mu_q        <= '0;
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid_i) begin
                        state_q     <= ST_LOAD;
                        cfg_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cfg_valid_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((cnt_q == '0) && !iss_valid_q) begin
                        state_q     <= ST_LOAD;
                        cfg_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    m_q     <= cfg_m_i;
                    mu_q    <= cfg_mu_i;
                    state_q <= ST_RUN;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Issue stage, tag pipeline, result routing, in-flight count, error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_valid_q  <= 1'b0;
            iss_x_q      <= '0;
            iss_id_q     <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            resp_valid_q <= '0;
            resp_r_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            iss_valid_q <= hs;
            if (hs) begin
                iss_x_q  <= req_x_i[gnt_id];
                iss_id_q <= gnt_id;
            end
            // Stage 0 follows the issue register so the last stage lines up
            // with bm_valid LATENCY cycles after bm_start.
            tag_q[0] <= '{valid: iss_valid_q, id: ID_W'(iss_id_q)};
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            resp_valid_q <= resp_valid_d;
            if (rsp_hit) begin
                resp_r_q <= bm.bm_result[DATA_W-1:0];
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign req_ready_o  = gnt;
    assign cfg_ready_o  = cfg_ready_q;
    assign bm.bm_start  = iss_valid_q;
    assign bm.bm_x      = iss_x_q;
    assign bm.bm_m      = m_q;
    assign bm.bm_mu     = mu_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_r_o     = resp_r_q;
    assign busy_o       = (state_q != ST_IDLE) && (cnt_q != '0);
    assign err_o        = err_q;

endmodule

// File: tb/tb_barrett_sched.sv
// Bench for barrett_sched with a behavioural LATENCY-cycle reduction model.
module tb_barrett_sched;
    import barrett_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][63:0]  req_x;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cfg_valid;
    logic [63:0]               cfg_m;
    logic [63:0]               cfg_mu;
    logic                      cfg_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [63:0]               resp_r;
    logic                      busy;
    logic                      err;
    logic                      inject;

    barrett_sched_if bm_if ();

    barrett_sched #(
        .NUM_REQ (NUM_REQ),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_x_i      (req_x),
        .req_ready_o  (req_ready),
        .cfg_valid_i  (cfg_valid),
        .cfg_m_i      (cfg_m),
        .cfg_mu_i     (cfg_mu),
        .cfg_ready_o  (cfg_ready),
        .bm           (bm_if),
        .resp_valid_o (resp_valid),
        .resp_r_o     (resp_r),
        .busy_o       (busy),
        .err_o        (err)
    );

    // Behavioural reduction unit: x mod m, captured at start, LATENCY cycles later.
    logic [LATENCY-1:0] mdl_v;
    logic [63:0]        mdl_r [LATENCY];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_v <= '0;
            for (int k = 0; k < LATENCY; k++) mdl_r[k] <= '0;
        end else begin
            mdl_v    <= {mdl_v[LATENCY-2:0], bm_if.bm_start};
            mdl_r[0] <= (bm_if.bm_m == 64'd0) ? 64'd0 : (bm_if.bm_x % bm_if.bm_m);
            for (int k = 1; k < LATENCY; k++) mdl_r[k] <= mdl_r[k-1];
        end
    end
    assign bm_if.bm_valid  = mdl_v[LATENCY-1] | inject;
    assign bm_if.bm_result = {64'd0, mdl_r[LATENCY-1]};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected result pushed at each handshake, popped at each response.
    typedef struct {
        int          id;
        logic [63:0] r;
        int          cyc;
    } sb_t;

    sb_t                sb [$];
    logic [63:0]        resp_log [$];
    logic [63:0]        m_cur = 64'd0;
    logic [63:0]        last_r;
    int                 last_id;
    int                 cyc = 0;
    int                 cfg_pulses = 0;
    logic [NUM_REQ-1:0] mon_hs;
    sb_t                mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            mon_hs = req_valid & req_ready;
            if (mon_hs != '0) begin
                chk("grant_onehot", 64'($countones(mon_hs)), 64'd1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (mon_hs[i]) begin
                        mon_e.id  = i;
                        mon_e.r   = req_x[i] % m_cur;
                        mon_e.cyc = cyc;
                        sb.push_back(mon_e);
                    end
                end
            end
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_route", 64'(resp_valid), 64'd1 << mon_e.id);
                    chk("resp_r", resp_r, mon_e.r);
                    chk("resp_latency", 64'(cyc - mon_e.cyc), 64'd6);
                    last_r = resp_r;
                    for (int i = 0; i < NUM_REQ; i++) if (resp_valid[i]) last_id = i;
                    resp_log.push_back(resp_r);
                end
            end
            if (cfg_ready) begin
                cfg_pulses++;
                m_cur = cfg_m;
            end
        end
    end

    task automatic issue(input int id, input logic [63:0] x, output bit ok);
        req_x[id]     = x;
        req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic do_cfg(input logic [63:0] m, input logic [63:0] mu, output bit ok);
        cfg_m     = m;
        cfg_mu    = mu;
        cfg_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (cfg_ready) ok = 1'b1;
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        int          id;
        logic [63:0] x;
        logic [63:0] exp_r;
    } vec_t;

    vec_t               tbl [6];
    logic [NUM_REQ-1:0] gseq [5];
    logic [NUM_REQ-1:0] gfirst;
    logic [NUM_REQ-1:0] acc_ready;
    logic [NUM_REQ-1:0] acc_resp;
    logic               acc_start;
    logic               drain_gnt;
    logic               busy_seen;
    bit                 ok;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        cfg_valid = 1'b0;
        cfg_m     = '0;
        cfg_mu    = '0;
        inject    = 1'b0;
        last_r    = '0;
        last_id   = -1;

        // m = 97 expectations, worked out by hand
        tbl[0] = '{0, 64'd1000, 64'h1E};
        tbl[1] = '{1, 64'd97, 64'h00};
        tbl[2] = '{2, 64'd96, 64'h60};
        tbl[3] = '{0, 64'd0, 64'h00};
        tbl[4] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3C};
        tbl[5] = '{3, 64'd12345, 64'h1A};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_r", resp_r, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_bm_start", 64'(bm_if.bm_start), 64'd0);
        chk("rst_bm_x", bm_if.bm_x, 64'd0);
        chk("rst_bm_m", bm_if.bm_m, 64'd0);
        chk("rst_bm_mu", bm_if.bm_mu, 64'd0);
        rst_n = 1'b1;
        tick();

        // IDLE gating: nobody is served before a modulus exists
        req_x     = {64'd4, 64'd3, 64'd2, 64'd1};
        req_valid = '1;
        acc_ready = '0;
        acc_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc_ready |= req_ready;
            acc_start |= bm_if.bm_start;
        end
        tick();
        req_valid = '0;
        chk("idle_no_ready", 64'(acc_ready), 64'd0);
        chk("idle_no_start", 64'(acc_start), 64'd0);

        do_cfg(64'd97, 64'h0A8F_5C28_F5C2_8F5C, ok);
        chk("cfg1_accept", 64'(ok), 64'd1);
        @(negedge clk);
        chk("cfg1_pulse_width", 64'(cfg_ready), 64'd0);
        chk("cfg1_bm_m", bm_if.bm_m, 64'd97);
        chk("cfg1_bm_mu", bm_if.bm_mu, 64'h0A8F_5C28_F5C2_8F5C);
        tick();

        for (int v = 0; v < 6; v++) begin
            last_r  = '1;
            last_id = -1;
            issue(tbl[v].id, tbl[v].x, ok);
            chk("tbl_grant", 64'(ok), 64'd1);
            if (v == 0) chk("busy_inflight", 64'(busy), 64'd1);
            repeat (8) tick();
            chk("tbl_r", last_r, tbl[v].exp_r);
            chk("tbl_id", 64'(last_id), 64'(tbl[v].id));
            if (v == 0) begin
                chk("busy_retired", 64'(busy), 64'd0);
                chk("cfg1_pulse_count", 64'(cfg_pulses), 64'd1);
            end
        end

        // Fairness: all requesters valid; last grant was 3
        resp_log.delete();
        for (int i = 0; i < NUM_REQ; i++) req_x[i] = 64'(100 + i);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            gseq[k] = req_ready;
        end
        tick();
        req_valid = '0;
        repeat (10) tick();
        for (int k = 0; k < 5; k++) chk("fair_grant", 64'(gseq[k]), 64'd1 << (k % 4));
        chk("fair_count", 64'(resp_log.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < resp_log.size()) chk("fair_r", resp_log[k], 64'(3 + (k % 4)));
        end

        // Configuration change with three operations in flight; last grant was 0
        resp_log.delete();
        req_x[0]  = 64'd400;
        req_x[1]  = 64'd200;
        req_x[2]  = 64'd300;
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            gseq[k] = req_ready;
        end
        tick();
        req_valid = 4'b1000;
        req_x[3]  = 64'd1000;
        cfg_m     = 64'd13;
        cfg_mu    = 64'h1234;
        cfg_valid = 1'b1;
        drain_gnt = 1'b0;
        busy_seen = 1'b0;
        ok        = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (req_ready != '0) drain_gnt = 1'b1;
            busy_seen |= busy;
            if (cfg_ready) ok = 1'b1;
        end
        tick();
        cfg_valid = 1'b0;
        @(negedge clk);
        gfirst = req_ready;
        tick();
        req_valid = '0;
        last_r  = '1;
        last_id = -1;
        repeat (8) tick();
        chk("mid_grant0", 64'(gseq[0]), 64'b0010);
        chk("mid_grant1", 64'(gseq[1]), 64'b0100);
        chk("mid_grant2", 64'(gseq[2]), 64'b0001);
        chk("mid_cfg_accept", 64'(ok), 64'd1);
        chk("mid_no_grant_drain", 64'(drain_gnt), 64'd0);
        chk("mid_busy_drain", 64'(busy_seen), 64'd1);
        chk("mid_first_grant", 64'(gfirst), 64'b1000);
        chk("mid_resp_count", 64'(resp_log.size()), 64'd4);
        if (resp_log.size() >= 3) begin
            chk("mid_old_m_0", resp_log[0], 64'd6);
            chk("mid_old_m_1", resp_log[1], 64'd9);
            chk("mid_old_m_2", resp_log[2], 64'd12);
        end
        chk("mid_new_m_r", last_r, 64'h0C);
        chk("mid_new_m_id", 64'(last_id), 64'd3);
        chk("mid_bm_m", bm_if.bm_m, 64'd13);
        chk("mid_bm_mu", bm_if.bm_mu, 64'h1234);
        chk("cfg_pulse_total", 64'(cfg_pulses), 64'd2);
        chk("mid_err", 64'(err), 64'd0);

        // Reset with two operations in flight; last grant was 3
        req_x[0]  = 64'd5;
        req_x[1]  = 64'd6;
        req_valid = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        tick();
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mrst_req_ready", 64'(req_ready), 64'd0);
        chk("mrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mrst_resp_r", resp_r, 64'd0);
        chk("mrst_bm_start", 64'(bm_if.bm_start), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_bm_m", bm_if.bm_m, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        acc_ready = '0;
        acc_resp  = '0;
        acc_start = 1'b0;
        busy_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            acc_ready |= req_ready;
            acc_resp  |= resp_valid;
            acc_start |= bm_if.bm_start;
            busy_seen |= busy;
        end
        tick();
        req_valid = '0;
        chk("post_rst_no_ready", 64'(acc_ready), 64'd0);
        chk("post_rst_no_resp", 64'(acc_resp), 64'd0);
        chk("post_rst_no_start", 64'(acc_start), 64'd0);
        chk("post_rst_busy", 64'(busy_seen), 64'd0);
        chk("post_rst_err", 64'(err), 64'd0);

        // Error injection: result strobe with an empty tag stage
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(err), 64'd1);
        repeat (5) tick();
        chk("err_sticky", 64'(err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("err_cleared_by_reset", 64'(err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
